pingpong_activation_store: RTL and testbench
============================================

# pingpong_activation_store

Double-buffered activation memory with one write port and `num_read` independent registered read ports. Two banks alternate roles. The producer (previous layer) fills the write bank while the consumer (processing-element array) reads the read bank. A single-cycle `swap` pulse exchanges the bank roles. Each bank tracks how many words were written to it, so reads beyond the filled region are flagged instead of returning stale data. The block sits between a layer's output stage and the next layer's operand fetch.

## Interface
- `value_width`, 16, bits per activation word
- `address_width`, 10, address bits; each bank holds 2**address_width words
- `num_read`, 2, number of read channels (≥1)

Ports:
- `clk`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  write strobe
- `wr_addr`  in  address_width  write address into the write bank
- `wr_data`  in  value_width  write value
- `swap`  in  1  single-cycle request to exchange bank roles
- `rd_en`  in  num_read  per-channel read strobe
- `rd_addr`  in  num_read*address_width  channel k at bits [k*address_width +: address_width]
- `rd_data`  out  num_read*value_width  channel k at bits [k*value_width +: value_width]
- `rd_valid`  out  num_read  per-channel data-valid, one cycle after `rd_en`
- `rd_oob`  out  num_read  per-channel out-of-bounds flag, qualified by `rd_valid`
- `rd_bank`  out  1  index of the current read bank; the write bank is `~rd_bank`
- `wr_count`  out  address_width+1  words written to the write bank since the last swap, saturating
- `rd_words`  out  address_width+1  fill level of the read bank, latched at swap

## Operation
- Memory: two arrays `[0:1][2**address_width-1:0]` of `value_width` bits. Array contents are not reset.
- Write
  - `wr_en`=1 writes `wr_data` to bank `~rd_bank` at `wr_addr`.
  - `wr_count` increments by 1 per write and saturates at 2**address_width.
  - `wr_count` counts write strobes, not distinct addresses. Rewriting an address still increments.
- Read, channel k
  - `rd_en[k]`=1 samples bank `rd_bank` at address `rd_addr[k]`.
  - If `rd_addr[k]` < `rd_words`: `rd_data[k]` = memory word and `rd_oob[k]` = 0.
  - Otherwise: `rd_data[k]` = 0 and `rd_oob[k]` = 1.
  - `rd_en[k]`=0: `rd_valid[k]` = 0 next cycle, and `rd_data[k]`/`rd_oob[k]` hold their previous values.
- Channels are fully independent. Any number of channels may read the same address in one cycle.
- Swap (`swap`=1 at an edge)
  - `rd_bank` toggles.
  - `rd_words` takes the value of `wr_count` as it stands including any write in the same cycle.
  - `wr_count` is cleared to 0.
- Back-to-back swaps are legal. Each swap toggles the banks again. A bank swapped in with no writes gives `rd_words`=0, so all its reads are OOB.
- Reads and writes target different banks at all times, so no read-during-write hazard exists.

## Timing
- Read latency: exactly 1 cycle from `rd_en` to `rd_valid`/`rd_data`/`rd_oob`, with no stalls. One read per channel per cycle.
- Write: takes effect at the edge where `wr_en` is sampled.
- Same-edge events with `swap`:
  - A read issued in the same cycle as `swap` uses the pre-swap `rd_bank` and `rd_words`.
  - A write issued in the same cycle as `swap` goes to the pre-swap write bank and is counted into the new `rd_words`.
  - A read of that bank on the cycle after the swap returns the written data.
- Reset (reset low, asynchronous, any time including mid-fill or mid-read):
  - `rd_bank`=0, `wr_count`=0, `rd_words`=0.
  - `rd_valid`=0, `rd_oob`=0, `rd_data`=0.
  - Memory contents are retained, but all reads after reset report OOB until the next swap.
- Saturation: after 2**address_width writes, `wr_count` holds at 2**address_width (MSB set, other bits 0). A full bank makes every address in-bounds.

## Test plan
- **Reset defaults.** Assert `reset`=0 mid-stream → all outputs 0 immediately. After release, a read at address 0 returns `rd_valid`=1, `rd_oob`=1, `rd_data`=0.
- **Fill, swap, read.** Write 0x1234 to addr 0 and 0xBEEF to addr 1, then pulse `swap` → `rd_bank`=1, `rd_words`=2, `wr_count`=0. Channel 0 reading addr 1 and channel 1 reading addr 0 → next cycle 0xBEEF and 0x1234, `rd_oob`=00.
- **Out of bounds.** With `rd_words`=2, read addr 2 → `rd_data`=0, `rd_oob`=1. Read addr 1023 → `rd_oob`=1.
- **Simultaneous events.** Issue `wr_en` (addr 5, 0x00AA), `swap`, and `rd_en` in one cycle → the read uses the old bank. `rd_words` = previous count + 1. A read of addr 5 on the next cycle returns 0x00AA.
- **Saturation.** Perform 1025 writes with `address_width`=10 → `wr_count`=1024. After swap, a read of addr 1023 has `rd_oob`=0.
- **Bank isolation.** Write the write bank continuously while both channels read the read bank every cycle for 50 cycles → read data unchanged and `rd_valid` high on every cycle following an `rd_en`.

Source files
------------

// File: rtl/pingpong_activation_store.sv
`default_nettype none
// ============================================================================
// Module      : pingpong_activation_store
// Description : Two-bank activation buffer; one bank fills while the other is
//               read through independent registered channels, with fill-level
//               bounds checking on every read.
// Revision    : 1.0 - initial release
// ============================================================================
module pingpong_activation_store #(
    parameter int VALUE_WIDTH   = 16,
    parameter int ADDRESS_WIDTH = 10,
    parameter int NUM_READ      = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wr_en,
    input  logic [ADDRESS_WIDTH-1:0]          wr_addr,
    input  logic [VALUE_WIDTH-1:0]            wr_data,
    input  logic                              swap,
    input  logic [NUM_READ-1:0]               rd_en,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*VALUE_WIDTH-1:0]   rd_data,
    output logic [NUM_READ-1:0]               rd_valid,
    output logic [NUM_READ-1:0]               rd_oob,
    output logic                              rd_bank,
    output logic [ADDRESS_WIDTH:0]            wr_count,
    output logic [ADDRESS_WIDTH:0]            rd_words
);

    localparam int                 C_DEPTH = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] C_FULL = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [ADDRESS_WIDTH:0] C_ONE  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

    logic [VALUE_WIDTH-1:0]   r_mem [0:1][0:C_DEPTH-1];
    logic                     r_rd_bank;
    logic [ADDRESS_WIDTH:0]   r_wr_count;
    logic [ADDRESS_WIDTH:0]   r_rd_words;
    logic [ADDRESS_WIDTH:0]   w_wr_count_next;

    // Count includes a write landing on the same edge as swap, so it is handed over.
    assign w_wr_count_next = (wr_en && (r_wr_count != C_FULL)) ? r_wr_count + C_ONE
                                                              : r_wr_count;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[~r_rd_bank][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_bank  <= 1'b0;
            r_wr_count <= '0;
            r_rd_words <= '0;
        end else if (swap) begin
            r_rd_bank  <= ~r_rd_bank;
            r_rd_words <= w_wr_count_next;
            r_wr_count <= '0;
        end else begin
            r_wr_count <= w_wr_count_next;
        end
    end

    assign rd_bank  = r_rd_bank;
    assign wr_count = r_wr_count;
    assign rd_words = r_rd_words;

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] w_addr;
        logic                     w_in_bounds;
        logic                     r_valid;
        logic                     r_oob;
        logic [VALUE_WIDTH-1:0]   r_data;

        assign w_addr      = rd_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign w_in_bounds = {1'b0, w_addr} < r_rd_words;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_valid <= 1'b0;
                r_oob   <= 1'b0;
                r_data  <= '0;
            end else begin
                r_valid <= rd_en[k];
                // Data and flag hold between strobes; only valid drops.
                if (rd_en[k]) begin
                    r_oob  <= ~w_in_bounds;
                    r_data <= w_in_bounds ? r_mem[r_rd_bank][w_addr] : '0;
                end
            end
        end

        assign rd_valid[k]                         = r_valid;
        assign rd_oob[k]                           = r_oob;
        assign rd_data[k*VALUE_WIDTH +: VALUE_WIDTH] = r_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_pingpong_activation_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_pingpong_activation_store
// Description : Directed self-checking bench for pingpong_activation_store.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pingpong_activation_store;

    localparam int AW = 10;
    localparam int VW = 16;
    localparam int NR = 2;

    logic             clk;
    logic             reset;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [VW-1:0]    wr_data;
    logic             swap;
    logic [NR-1:0]    rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*VW-1:0] rd_data;
    logic [NR-1:0]    rd_valid;
    logic [NR-1:0]    rd_oob;
    logic             rd_bank;
    logic [AW:0]      wr_count;
    logic [AW:0]      rd_words;

    int vectors;
    int miscompares;

    pingpong_activation_store #(
        .VALUE_WIDTH   (VW),
        .ADDRESS_WIDTH (AW),
        .NUM_READ      (NR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .swap     (swap),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_oob   (rd_oob),
        .rd_bank  (rd_bank),
        .wr_count (wr_count),
        .rd_words (rd_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; swap = 1'b0; rd_en = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0; idle(); wr_addr = '0; wr_data = '0; rd_addr = '0;
        tick(); tick();
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 10'd0; wr_data = 16'h1111; tick();
        wr_en = 1'b0; swap = 1'b1; tick();
        swap = 1'b0; rd_en = 2'b01; rd_addr = {10'd0, 10'd0}; tick();
        vectors++;
        if (rd_data[15:0] !== 16'h1111 || rd_valid !== 2'b01) begin
            miscompares++;
            $display("FAIL pre_reset_read: data=%h valid=%b, required data=1111 valid=01", rd_data[15:0], rd_valid);
        end
        // Drop reset between edges; outputs must clear without a clock.
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (rd_valid !== 2'b00 || rd_oob !== 2'b00 || rd_data !== 32'h0 ||
            rd_bank !== 1'b0 || wr_count !== 11'd0 || rd_words !== 11'd0) begin
            miscompares++;
            $display("FAIL async_reset: valid=%b oob=%b data=%h bank=%b wcnt=%0d rwords=%0d, required all zero",
                     rd_valid, rd_oob, rd_data, rd_bank, wr_count, rd_words);
        end
        idle(); tick();
        reset = 1'b1;
        rd_en = 2'b11; rd_addr = {10'd0, 10'd0}; tick();
        vectors++;
        if (rd_valid !== 2'b11 || rd_oob !== 2'b11 || rd_data !== 32'h0) begin
            miscompares++;
            $display("FAIL post_reset_oob: valid=%b oob=%b data=%h, required valid=11 oob=11 data=0", rd_valid, rd_oob, rd_data);
        end
        idle(); tick();
    endtask

    task automatic test_fill_swap();
        wr_en = 1'b1; wr_addr = 10'd0; wr_data = 16'h1234; tick();
        wr_addr = 10'd1; wr_data = 16'hBEEF; tick();
        vectors++;
        if (wr_count !== 11'd2) begin
            miscompares++;
            $display("FAIL fill_count: wr_count=%0d, required 2", wr_count);
        end
        wr_en = 1'b0; swap = 1'b1; tick();
        swap = 1'b0;
        vectors++;
        if (rd_bank !== 1'b1 || rd_words !== 11'd2 || wr_count !== 11'd0) begin
            miscompares++;
            $display("FAIL swap_state: bank=%b rwords=%0d wcnt=%0d, required bank=1 rwords=2 wcnt=0", rd_bank, rd_words, wr_count);
        end
        rd_en = 2'b11; rd_addr = {10'd0, 10'd1}; tick();
        vectors++;
        if (rd_data !== 32'h1234_BEEF || rd_oob !== 2'b00 || rd_valid !== 2'b11) begin
            miscompares++;
            $display("FAIL swap_read: data=%h oob=%b valid=%b, required data=1234beef oob=00 valid=11", rd_data, rd_oob, rd_valid);
        end
        rd_en = 2'b00; tick();
        vectors++;
        if (rd_valid !== 2'b00 || rd_data !== 32'h1234_BEEF || rd_oob !== 2'b00) begin
            miscompares++;
            $display("FAIL read_hold: valid=%b data=%h oob=%b, required valid=00 data=1234beef oob=00", rd_valid, rd_data, rd_oob);
        end
    endtask

    task automatic test_oob();
        rd_en = 2'b11; rd_addr = {10'd1023, 10'd2}; tick();
        vectors++;
        if (rd_oob !== 2'b11 || rd_data !== 32'h0 || rd_valid !== 2'b11) begin
            miscompares++;
            $display("FAIL oob_high: oob=%b data=%h valid=%b, required oob=11 data=0 valid=11", rd_oob, rd_data, rd_valid);
        end
        rd_addr = {10'd2, 10'd1}; tick();
        vectors++;
        if (rd_oob !== 2'b10 || rd_data !== 32'h0000_BEEF) begin
            miscompares++;
            $display("FAIL oob_edge: oob=%b data=%h, required oob=10 data=0000beef", rd_oob, rd_data);
        end
        idle(); tick();
    endtask

    task automatic test_simultaneous();
        // Write bank is 0 now; put five words at addresses 0..4.
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_addr = AW'(i); wr_data = 16'h0100 + VW'(i); tick();
        end
        wr_addr = 10'd5; wr_data = 16'h00AA; swap = 1'b1;
        rd_en = 2'b01; rd_addr = {10'd0, 10'd1}; tick();
        idle();
        vectors++;
        if (rd_data[15:0] !== 16'hBEEF || rd_oob[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL same_edge_read: data=%h oob=%b, required data=beef oob=0", rd_data[15:0], rd_oob[0]);
        end
        vectors++;
        if (rd_bank !== 1'b0 || rd_words !== 11'd6 || wr_count !== 11'd0) begin
            miscompares++;
            $display("FAIL same_edge_swap: bank=%b rwords=%0d wcnt=%0d, required bank=0 rwords=6 wcnt=0", rd_bank, rd_words, wr_count);
        end
        rd_en = 2'b11; rd_addr = {10'd3, 10'd5}; tick();
        vectors++;
        if (rd_data !== 32'h0103_00AA || rd_oob !== 2'b00) begin
            miscompares++;
            $display("FAIL same_edge_write: data=%h oob=%b, required data=010300aa oob=00", rd_data, rd_oob);
        end
        idle(); tick();
    endtask

    task automatic test_saturation();
        wr_en = 1'b1;
        for (int i = 0; i < 1025; i++) begin
            wr_addr = AW'(i % 1024); wr_data = VW'(i) ^ 16'h5A5A; tick();
            if (i == 1023) begin
                vectors++;
                if (wr_count !== 11'd1024) begin
                    miscompares++;
                    $display("FAIL sat_reach: wr_count=%0d, required 1024", wr_count);
                end
            end
        end
        wr_en = 1'b0;
        vectors++;
        if (wr_count !== 11'h400) begin
            miscompares++;
            $display("FAIL sat_hold: wr_count=%h, required 400", wr_count);
        end
        swap = 1'b1; tick(); swap = 1'b0;
        vectors++;
        if (rd_words !== 11'd1024 || rd_bank !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_swap: rwords=%0d bank=%b, required rwords=1024 bank=1", rd_words, rd_bank);
        end
        rd_en = 2'b11; rd_addr = {10'd0, 10'd1023}; tick();
        vectors++;
        if (rd_data !== 32'h5E5A_59A5 || rd_oob !== 2'b00) begin
            miscompares++;
            $display("FAIL sat_read: data=%h oob=%b, required data=5e5a59a5 oob=00", rd_data, rd_oob);
        end
        idle(); tick();
    endtask

    task automatic test_isolation();
        logic [VW-1:0] exp0, exp1;
        logic [AW-1:0] a0, a1;
        wr_en = 1'b1; wr_data = 16'hFFFF; rd_en = 2'b11;
        for (int i = 0; i < 50; i++) begin
            a0 = AW'(i); a1 = AW'(1023 - i);
            wr_addr = AW'(i); rd_addr = {a1, a0};
            tick();
            exp0 = (a0 == 0) ? 16'h5E5A : ({6'd0, a0} ^ 16'h5A5A);
            exp1 = {6'd0, a1} ^ 16'h5A5A;
            vectors++;
            if (rd_valid !== 2'b11 || rd_oob !== 2'b00 || rd_data !== {exp1, exp0}) begin
                miscompares++;
                $display("FAIL isolation[%0d]: valid=%b oob=%b data=%h, required valid=11 oob=00 data=%h",
                         i, rd_valid, rd_oob, rd_data, {exp1, exp0});
            end
        end
        idle(); tick();
        vectors++;
        if (wr_count !== 11'd50) begin
            miscompares++;
            $display("FAIL isolation_count: wr_count=%0d, required 50", wr_count);
        end
    endtask

    task automatic test_back_to_back();
        swap = 1'b1; tick();
        vectors++;
        if (rd_bank !== 1'b0 || rd_words !== 11'd50 || wr_count !== 11'd0) begin
            miscompares++;
            $display("FAIL b2b_first: bank=%b rwords=%0d wcnt=%0d, required bank=0 rwords=50 wcnt=0", rd_bank, rd_words, wr_count);
        end
        tick();
        swap = 1'b0;
        vectors++;
        if (rd_bank !== 1'b1 || rd_words !== 11'd0) begin
            miscompares++;
            $display("FAIL b2b_second: bank=%b rwords=%0d, required bank=1 rwords=0", rd_bank, rd_words);
        end
        rd_en = 2'b11; rd_addr = {10'd0, 10'd0}; tick();
        vectors++;
        if (rd_oob !== 2'b11 || rd_data !== 32'h0 || rd_valid !== 2'b11) begin
            miscompares++;
            $display("FAIL b2b_empty_read: oob=%b data=%h valid=%b, required oob=11 data=0 valid=11", rd_oob, rd_data, rd_valid);
        end
        idle(); tick();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_fill_swap();
        test_oob();
        test_simultaneous();
        test_saturation();
        test_isolation();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
